// File: rtl/vid_pkg.sv
// Shared types and helpers for the video output mux: FSM encoding, blank colour, bus slicing.
package vid_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_PENDING = 2'd1,
    ST_MUTE    = 2'd2
  } vid_state_e;

  localparam logic [15:0] VID_BLANK_DEFAULT = 16'h8080;

  // LSB position of source idx inside a packed multi-source bus.
  function automatic int vid_slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/vid_frame_watchdog.sv
// Frame boundary detector on the selected source's vsync plus a saturating
// cycles-since-boundary counter used to force a switch away from a dead source.
module vid_frame_watchdog #(
  parameter int NUM_CH      = 2,
  parameter int SEL_W       = 3,
  parameter int WDOG_CYCLES = 2**22
) (
  input  logic              vid_clk,
  input  logic              vid_rst,
  input  logic [NUM_CH-1:0] i_vsync,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_clr,
  output logic              o_boundary,
  output logic              o_expired
);

  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [NUM_CH-1:0] r_vs_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] w_rise;
  logic              w_boundary;

  // History is kept per source so a select change never fakes an edge.
  always_comb begin
    w_rise     = i_vsync & ~r_vs_d;
    w_boundary = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_boundary = (i_sel == SEL_W'(i)) ? w_rise[i] : w_boundary;
    end
  end

  always_ff @(posedge vid_clk or posedge vid_rst) begin
    if (vid_rst) begin
      r_vs_d <= {NUM_CH{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_vs_d <= i_vsync;
      if (i_clr || w_boundary) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt != CNT_W'(WDOG_CYCLES)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_boundary = w_boundary;
  assign o_expired  = (r_cnt >= CNT_W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/vid_output_mux.sv
// N-source native-video output mux with frame-aligned switching, post-switch mute
// and a vsync-loss watchdog; all outputs registered, one cycle of latency.
module vid_output_mux
  import vid_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                DATA_W      = 16,
  parameter int                SEL_W       = 3,
  parameter int                MUTE_FRAMES = 1,
  parameter int                WDOG_CYCLES = 2**22,
  parameter logic [DATA_W-1:0] BLANK_DATA  = DATA_W'(VID_BLANK_DEFAULT)
) (
  input  logic                     vid_clk,
  input  logic                     vid_rst,
  input  logic [NUM_CH-1:0]        vid_in_active_video,
  input  logic [NUM_CH-1:0]        vid_in_hblank,
  input  logic [NUM_CH-1:0]        vid_in_vblank,
  input  logic [NUM_CH-1:0]        vid_in_hsync,
  input  logic [NUM_CH-1:0]        vid_in_vsync,
  input  logic [NUM_CH*DATA_W-1:0] vid_in_data,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     force_blank,
  output logic                     vid_out_active_video,
  output logic                     vid_out_hblank,
  output logic                     vid_out_vblank,
  output logic                     vid_out_hsync,
  output logic                     vid_out_vsync,
  output logic [DATA_W-1:0]        vid_out_data,
  output logic [SEL_W-1:0]         sel_active,
  output logic                     switch_pending,
  output logic                     wdog_trip,
  output logic [15:0]              switch_count
);

  localparam int MW = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES + 1) : 1;

  vid_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel_active, w_sel_nxt;
  logic [MW-1:0]     r_mute_cnt, w_mute_nxt;
  logic [15:0]       r_switch_count;
  logic              r_pending, r_wdog_trip, w_trip_nxt, w_switch;
  logic              w_req_valid, w_req_diff, w_boundary, w_expired, w_blank;
  logic              w_mux_de, w_mux_hb, w_mux_vb, w_mux_hs, w_mux_vs;
  logic [DATA_W-1:0] w_mux_data;
  logic              r_out_de, r_out_hb, r_out_vb, r_out_hs, r_out_vs;
  logic [DATA_W-1:0] r_out_data;

  vid_frame_watchdog #(
    .NUM_CH      (NUM_CH),
    .SEL_W       (SEL_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .vid_clk    (vid_clk),
    .vid_rst    (vid_rst),
    .i_vsync    (vid_in_vsync),
    .i_sel      (r_sel_active),
    .i_clr      (w_switch),
    .o_boundary (w_boundary),
    .o_expired  (w_expired)
  );

  assign w_req_valid = ({1'b0, sel_req} < (SEL_W + 1)'(NUM_CH));
  assign w_req_diff  = w_req_valid && (sel_req != r_sel_active);

  always_comb begin
    w_mux_de   = 1'b0;
    w_mux_hb   = 1'b0;
    w_mux_vb   = 1'b0;
    w_mux_hs   = 1'b0;
    w_mux_vs   = 1'b0;
    w_mux_data = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel_active == SEL_W'(i)) begin
        w_mux_de   = vid_in_active_video[i];
        w_mux_hb   = vid_in_hblank[i];
        w_mux_vb   = vid_in_vblank[i];
        w_mux_hs   = vid_in_hsync[i];
        w_mux_vs   = vid_in_vsync[i];
        w_mux_data = vid_in_data[vid_slice_lsb(i, DATA_W) +: DATA_W];
      end else begin
        w_mux_de = w_mux_de;
      end
    end
  end

  // A boundary wins over a simultaneous watchdog expiry, so no trip is reported then.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel_active;
    w_mute_nxt  = r_mute_cnt;
    w_switch    = 1'b0;
    w_trip_nxt  = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_req_diff) w_state_nxt = ST_PENDING;
        else            w_state_nxt = ST_LOCKED;
      end
      ST_PENDING: begin
        if (!w_req_diff) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_boundary || w_expired) begin
          w_switch    = 1'b1;
          w_trip_nxt  = !w_boundary;
          w_sel_nxt   = sel_req;
          w_mute_nxt  = {MW{1'b0}};
          w_state_nxt = (MUTE_FRAMES > 0) ? ST_MUTE : ST_LOCKED;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_MUTE: begin
        if (!w_boundary) begin
          w_state_nxt = ST_MUTE;
        end else if (r_mute_cnt >= MW'(MUTE_FRAMES - 1)) begin
          w_mute_nxt  = {MW{1'b0}};
          w_state_nxt = w_req_diff ? ST_PENDING : ST_LOCKED;
        end else begin
          w_mute_nxt  = r_mute_cnt + MW'(1);
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  always_ff @(posedge vid_clk or posedge vid_rst) begin
    if (vid_rst) begin
      r_state        <= ST_LOCKED;
      r_sel_active   <= {SEL_W{1'b0}};
      r_mute_cnt     <= {MW{1'b0}};
      r_switch_count <= 16'd0;
      r_pending      <= 1'b0;
      r_wdog_trip    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sel_active   <= w_sel_nxt;
      r_mute_cnt     <= w_mute_nxt;
      r_switch_count <= w_switch ? r_switch_count + 16'd1 : r_switch_count;
      r_pending      <= (w_state_nxt == ST_PENDING);
      r_wdog_trip    <= w_trip_nxt;
    end
  end

  // Blanking only touches DE/data; sync and blank flags always follow the source.
  assign w_blank = force_blank || (r_state == ST_MUTE);

  always_ff @(posedge vid_clk or posedge vid_rst) begin
    if (vid_rst) begin
      r_out_de   <= 1'b0;
      r_out_hb   <= 1'b0;
      r_out_vb   <= 1'b0;
      r_out_hs   <= 1'b0;
      r_out_vs   <= 1'b0;
      r_out_data <= {DATA_W{1'b0}};
    end else begin
      r_out_de   <= w_mux_de && !w_blank;
      r_out_hb   <= w_mux_hb;
      r_out_vb   <= w_mux_vb;
      r_out_hs   <= w_mux_hs;
      r_out_vs   <= w_mux_vs;
      r_out_data <= w_blank ? BLANK_DATA : w_mux_data;
    end
  end

  assign vid_out_active_video = r_out_de;
  assign vid_out_hblank       = r_out_hb;
  assign vid_out_vblank       = r_out_vb;
  assign vid_out_hsync        = r_out_hs;
  assign vid_out_vsync        = r_out_vs;
  assign vid_out_data         = r_out_data;
  assign sel_active           = r_sel_active;
  assign switch_pending       = r_pending;
  assign wdog_trip            = r_wdog_trip;
  assign switch_count         = r_switch_count;

endmodule
